// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: runs one 1-bit AND/OR/add slice over a WIDTH-bit operation,
// LSB first, one bit per cycle. A carry flop links the bits. Flags and a done pulse follow.
//   state  | meaning
//   IDLE   | waiting for start_i, operands not yet latched
//   RUN    | one slice evaluation per cycle, bit[cnt_q]
//   DONE   | one-cycle done_o pulse, result/flags valid
module bit_serial_alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       alu_ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;

    logic             ainv, binv, valid, arith;
    logic [1:0]       op;
    logic             bit_a, bit_b, sum, s_cout, res_bit;
    logic [WIDTH-1:0] final_res;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctrl_q   <= ctrl_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Slice decode and evaluation on the current bit of the latched operands.
    always_comb begin
        ainv  = ctrl_q[3];
        binv  = ctrl_q[2];
        op    = ctrl_q[1:0];
        valid = (ctrl_q == 4'b0000) || (ctrl_q == 4'b0001) || (ctrl_q == 4'b0010) ||
                (ctrl_q == 4'b0110) || (ctrl_q == 4'b0111) || (ctrl_q == 4'b1100);
        arith = valid && op[1];

        bit_a  = a_q[cnt_q] ^ ainv;
        bit_b  = b_q[cnt_q] ^ binv;
        sum    = bit_a ^ bit_b ^ carry_q;
        s_cout = (bit_a & bit_b) | (carry_q & (bit_a ^ bit_b));

        res_bit = 1'b0;
        if (valid) begin
            case (op)
                2'b00:   res_bit = bit_a & bit_b;
                2'b01:   res_bit = bit_a | bit_b;
                2'b10:   res_bit = sum;
                default: res_bit = 1'b0;
            endcase
        end

        acc_d        = acc_q;
        acc_d[cnt_q] = res_bit;

        final_res = '0;
        if (valid) begin
            if (op == 2'b11) final_res[0] = sum;
            else             final_res = acc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_d     = src1_i;
                    b_d     = src2_i;
                    ctrl_d  = alu_ctrl_i;
                    cnt_d   = '0;
                    carry_d = alu_ctrl_i[2];
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                carry_d = s_cout;
                if (cnt_q == LAST) begin
                    result_d = final_res;
                    zero_d   = (final_res == '0);
                    cout_d   = arith & s_cout;
                    ovf_d    = arith & (carry_q ^ s_cout);
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed self-checking bench for bit_serial_alu_ctrl (WIDTH=32): hand-computed results,
// latency, reset abort and back-to-back start behaviour.
module tb_bit_serial_alu_ctrl;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [3:0]   alu_ctrl_i;
    logic [W-1:0] src1_i, src2_i;
    logic         busy_o, done_o, zero_o, cout_o, overflow_o;
    logic [W-1:0] result_o;

    int n_checks = 0;
    int n_fail   = 0;

    bit_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .alu_ctrl_i (alu_ctrl_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .cout_o     (cout_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts one op; returns edges from accept to done_o and result_o seen mid-run.
    task automatic do_op(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [W-1:0] mid_res);
        @(negedge clk_i);
        start_i = 1'b1; alu_ctrl_i = ctrl; src1_i = a; src2_i = b;
        @(negedge clk_i);
        start_i = 1'b0;
        lat = 1;
        mid_res = result_o;
        while (done_o !== 1'b1 && lat < 100) begin
            @(negedge clk_i);
            lat++;
            if (lat == 5) mid_res = result_o;
        end
    endtask

    task automatic chk_op(input string tag, input int lat, input logic [W-1:0] res,
                          input logic z, input logic c, input logic o);
        chk({tag, "_lat"}, W'(lat), 32'd33);
        chk({tag, "_res"}, result_o, res);
        chk({tag, "_zero"}, W'(zero_o), W'(z));
        chk({tag, "_cout"}, W'(cout_o), W'(c));
        chk({tag, "_ovf"}, W'(overflow_o), W'(o));
        chk({tag, "_busy"}, W'(busy_o), 32'd1);
        @(negedge clk_i);
        chk({tag, "_done_pulse"}, W'(done_o), 32'd0);
        chk({tag, "_idle"}, W'(busy_o), 32'd0);
    endtask

    initial begin
        int lat, k, low;
        logic [W-1:0] mid;
        logic saw_done;

        rst_i = 1'b1; start_i = 1'b0; alu_ctrl_i = 4'b0000; src1_i = '0; src2_i = '0;
        repeat (2) @(negedge clk_i);
        chk("rst_busy", W'(busy_o), 32'd0);
        chk("rst_done", W'(done_o), 32'd0);
        chk("rst_res", result_o, 32'd0);
        chk("rst_zero", W'(zero_o), 32'd0);
        chk("rst_cout", W'(cout_o), 32'd0);
        chk("rst_ovf", W'(overflow_o), 32'd0);
        rst_i = 1'b0;

        do_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, lat, mid);
        chk_op("add_ovf", lat, 32'h8000_0000, 1'b0, 1'b0, 1'b1);

        // Reset mid-run aborts and clears the previous (nonzero) result and flags.
        @(negedge clk_i);
        start_i = 1'b1; alu_ctrl_i = 4'b0010; src1_i = 32'd5; src2_i = 32'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        chk("pre_rst_busy", W'(busy_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("abort_busy", W'(busy_o), 32'd0);
        chk("abort_res", result_o, 32'd0);
        chk("abort_ovf", W'(overflow_o), 32'd0);
        chk("abort_done", W'(done_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (done_o === 1'b1) saw_done = 1'b1;
        end
        chk("abort_no_done", W'(saw_done), 32'd0);
        chk("abort_idle", W'(busy_o), 32'd0);

        do_op(4'b0010, 32'd5, 32'd3, lat, mid);
        chk_op("add_after_rst", lat, 32'd8, 1'b0, 1'b0, 1'b0);

        do_op(4'b0110, 32'd5, 32'd5, lat, mid);
        chk_op("sub_eq", lat, 32'd0, 1'b1, 1'b1, 1'b0);
        do_op(4'b0110, 32'd3, 32'd5, lat, mid);
        chk_op("sub_neg", lat, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

        do_op(4'b0111, 32'hFFFF_FFFE, 32'd3, lat, mid);
        chk_op("slt_true", lat, 32'd1, 1'b0, 1'b1, 1'b0);
        do_op(4'b0111, 32'd7, 32'd2, lat, mid);
        chk_op("slt_false", lat, 32'd0, 1'b1, 1'b1, 1'b0);

        do_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, mid);
        chk_op("and", lat, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
        do_op(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, mid);
        chk("or_hold_old", mid, 32'hF000_F000);
        chk_op("or", lat, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
        do_op(4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, mid);
        chk_op("nor", lat, 32'h000F_000F, 1'b0, 1'b0, 1'b0);

        // start_i held high: operand changes during RUN must not be picked up.
        @(negedge clk_i);
        start_i = 1'b1; alu_ctrl_i = 4'b0010; src1_i = 32'd10; src2_i = 32'd20;
        k = 0;
        while (done_o !== 1'b1 && k < 100) begin
            @(negedge clk_i);
            k++;
            if (k == 3) begin src1_i = 32'd100; src2_i = 32'd200; end
        end
        chk("b2b1_res", result_o, 32'd30);

        k = 0; low = 0;
        do begin
            @(negedge clk_i);
            k++;
            if (busy_o !== 1'b1) low++;
            if (k == 3) alu_ctrl_i = 4'b1111;
        end while (done_o !== 1'b1 && k < 100);
        chk("b2b2_period", W'(k), 32'd34);
        chk("b2b2_busy_gap", W'(low), 32'd1);
        chk("b2b2_res", result_o, 32'd300);
        chk("b2b2_cout", W'(cout_o), 32'd0);

        k = 0; low = 0;
        do begin
            @(negedge clk_i);
            k++;
            if (busy_o !== 1'b1) low++;
        end while (done_o !== 1'b1 && k < 100);
        start_i = 1'b0;
        chk("b2b3_period", W'(k), 32'd34);
        chk("b2b3_busy_gap", W'(low), 32'd1);
        chk("inv_res", result_o, 32'd0);
        chk("inv_zero", W'(zero_o), 32'd1);
        chk("inv_cout", W'(cout_o), 32'd0);
        chk("inv_ovf", W'(overflow_o), 32'd0);
        repeat (3) @(negedge clk_i);
        chk("final_idle", W'(busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
